task_issue_scheduler: RTL and testbench

- Sits between the ProSparsity dispatcher and the PE processor.
- Buffers dispatched tasks and issues each one only after its prefix row has retired from the processor pipeline, bounding in-flight tasks.
- Detects tile end, drains, pulses tile completion, and clears the per-tile retired scoreboard.
- Drives the dispatcher's proc_ready and prev_compute_busy.

---
 rtl/task_issue_scheduler_pkg.sv | 27 ++
 rtl/task_issue_scheduler_fifo.sv | 64 ++++++
 rtl/task_issue_scheduler.sv | 148 ++++++++++++++
 tb/tb_task_issue_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_issue_scheduler_pkg.sv
// Shared task record, FSM encodings and the no-prefix convention for the
// task issue scheduler.
package task_issue_scheduler_pkg;

  localparam int ROWS          = 256;
  localparam int PATTERN_WIDTH = 16;
  localparam int IDX_W         = $clog2(ROWS);
  localparam int TASK_W        = 2 * IDX_W + PATTERN_WIDTH;

  typedef struct packed {
    logic [IDX_W-1:0]         row_id;
    logic [IDX_W-1:0]         prefix_id;
    logic [PATTERN_WIDTH-1:0] pattern;
  } sched_task_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } sched_state_e;

  // A task whose prefix points at itself has no dependency.
  function automatic logic has_no_prefix(input sched_task_t t);
    return t.prefix_id == t.row_id;
  endfunction

endpackage

// File: rtl/task_issue_scheduler_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; the head entry is read
// straight from storage flops so it stays stable until popped.
module sched_task_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/task_issue_scheduler.sv
// Buffers dispatched tasks and issues each in order once its prefix row has
// retired, bounding in-flight work and sequencing tile completion.
//
// state   | meaning
// S_RUN   | accepting tasks from the dispatcher, issuing eligible heads
// S_DRAIN | tile done seen; no new tasks, issue until empty and retired
// S_DONE  | one cycle: tile_complete pulse, scoreboard and stall count cleared
module task_issue_scheduler
  import task_issue_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int STALL_LIMIT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     disp_task_valid,
  input  logic [IDX_W-1:0]         disp_task_row_id,
  input  logic [IDX_W-1:0]         disp_task_prefix_id,
  input  logic [PATTERN_WIDTH-1:0] disp_task_pattern,
  input  logic                     disp_tile_done,
  output logic                     sched_ready,
  output logic                     compute_busy,
  output logic                     proc_valid,
  output logic [IDX_W-1:0]         proc_row_id,
  output logic [IDX_W-1:0]         proc_prefix_id,
  output logic [PATTERN_WIDTH-1:0] proc_pattern,
  input  logic                     proc_ready,
  input  logic                     retire_valid,
  input  logic [IDX_W-1:0]         retire_row,
  output logic                     tile_complete,
  output logic                     err_deadlock,
  output logic                     err_overflow
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W   = $clog2(MAX_INFLIGHT + 1);
  localparam int STALL_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

  sched_state_e     state_q, state_d;
  logic [ROWS-1:0]  retired_q, retired_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hold_q, hold_d;
  logic             err_deadlock_q, err_deadlock_d;
  logic             err_overflow_q, err_overflow_d;

  sched_task_t      wr_task, head;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             prefix_ok, cap_ok, stalled, force_issue, issue, retire_ok;

  assign wr_task = '{row_id:    disp_task_row_id,
                     prefix_id: disp_task_prefix_id,
                     pattern:   disp_task_pattern};

  sched_task_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TASK_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (disp_task_valid),
    .pop   (issue),
    .wdata (wr_task),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign prefix_ok   = has_no_prefix(head) || retired_q[head.prefix_id];
  assign cap_ok      = (inflight_q < INF_W'(MAX_INFLIGHT));
  assign stalled     = !fifo_empty && !prefix_ok && (inflight_q == '0);
  // Nothing in flight can ever retire the missing prefix, so force it out.
  assign force_issue = stalled && (stall_cnt_q == STALL_W'(STALL_LIMIT - 1));

  assign proc_valid     = !fifo_empty && (hold_q || (prefix_ok && cap_ok) || force_issue);
  assign proc_row_id    = head.row_id;
  assign proc_prefix_id = head.prefix_id;
  assign proc_pattern   = head.pattern;

  assign issue     = proc_valid && proc_ready;
  assign retire_ok = retire_valid && (inflight_q != '0);

  // Dispatcher looks at ready a cycle ahead of its pulse, hence two free slots.
  assign sched_ready   = (state_q == S_RUN) && (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
  assign compute_busy  = !fifo_empty || (inflight_q != '0) || proc_valid;
  assign tile_complete = (state_q == S_DONE);
  assign err_deadlock  = err_deadlock_q;
  assign err_overflow  = err_overflow_q;

  always_comb begin
    state_d        = state_q;
    retired_d      = retired_q;
    inflight_d     = inflight_q;
    stall_cnt_d    = '0;
    hold_d         = proc_valid && !proc_ready;
    err_deadlock_d = err_deadlock_q || force_issue;
    err_overflow_d = err_overflow_q || (disp_task_valid && fifo_full && !issue);

    if (retire_valid) retired_d[retire_row] = 1'b1;

    unique case ({issue, retire_ok})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (stalled) stall_cnt_d = force_issue ? stall_cnt_q : stall_cnt_q + STALL_W'(1);

    unique case (state_q)
      S_RUN: begin
        if (disp_tile_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && (inflight_q == '0) && !proc_valid) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_RUN;
        retired_d   = '0;
        stall_cnt_d = '0;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      retired_q      <= '0;
      inflight_q     <= '0;
      stall_cnt_q    <= '0;
      hold_q         <= 1'b0;
      err_deadlock_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      retired_q      <= retired_d;
      inflight_q     <= inflight_d;
      stall_cnt_q    <= stall_cnt_d;
      hold_q         <= hold_d;
      err_deadlock_q <= err_deadlock_d;
      err_overflow_q <= err_overflow_d;
    end
  end

endmodule

// File: tb/tb_task_issue_scheduler.sv
// Self-checking bench for task_issue_scheduler: eligibility vector table plus
// hand sequences, with issued tasks checked against a scoreboard queue.
module tb_task_issue_scheduler;
  import task_issue_scheduler_pkg::*;

  localparam int STALL_LIMIT = 1024;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     disp_task_valid = 1'b0;
  logic [IDX_W-1:0]         disp_task_row_id = '0;
  logic [IDX_W-1:0]         disp_task_prefix_id = '0;
  logic [PATTERN_WIDTH-1:0] disp_task_pattern = '0;
  logic                     disp_tile_done = 1'b0;
  logic                     sched_ready, compute_busy, proc_valid;
  logic [IDX_W-1:0]         proc_row_id, proc_prefix_id;
  logic [PATTERN_WIDTH-1:0] proc_pattern;
  logic                     proc_ready = 1'b0;
  logic                     retire_valid = 1'b0;
  logic [IDX_W-1:0]         retire_row = '0;
  logic                     tile_complete, err_deadlock, err_overflow;

  always #5 clk = ~clk;

  task_issue_scheduler #(
    .FIFO_DEPTH   (4),
    .MAX_INFLIGHT (8),
    .STALL_LIMIT  (STALL_LIMIT)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .disp_task_valid     (disp_task_valid),
    .disp_task_row_id    (disp_task_row_id),
    .disp_task_prefix_id (disp_task_prefix_id),
    .disp_task_pattern   (disp_task_pattern),
    .disp_tile_done      (disp_tile_done),
    .sched_ready         (sched_ready),
    .compute_busy        (compute_busy),
    .proc_valid          (proc_valid),
    .proc_row_id         (proc_row_id),
    .proc_prefix_id      (proc_prefix_id),
    .proc_pattern        (proc_pattern),
    .proc_ready          (proc_ready),
    .retire_valid        (retire_valid),
    .retire_row          (retire_row),
    .tile_complete       (tile_complete),
    .err_deadlock        (err_deadlock),
    .err_overflow        (err_overflow)
  );

  typedef struct {
    int row;
    int prefix;
    int pat;
  } exp_t;

  typedef struct {
    bit do_ret;
    int ret_row;
    int row;
    int prefix;
    bit exp_valid;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_count = 0;
  int last_issue_cyc = 0;
  int tc_count = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (tile_complete) tc_count++;
    if (proc_valid && proc_ready) begin
      issue_count++;
      last_issue_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual_row=%0d expected=none", proc_row_id);
      end else begin
        e = sb.pop_front();
        check("issue_row", int'(proc_row_id), e.row);
        check("issue_prefix", int'(proc_prefix_id), e.prefix);
        check("issue_pattern", int'(proc_pattern), e.pat);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push_task(input int row, input int prefix, input int pat, input bit track);
    exp_t e;
    disp_task_valid     = 1'b1;
    disp_task_row_id    = IDX_W'(row);
    disp_task_prefix_id = IDX_W'(prefix);
    disp_task_pattern   = PATTERN_WIDTH'(pat);
    if (track) begin
      e.row = row; e.prefix = prefix; e.pat = pat;
      sb.push_back(e);
    end
    step();
    disp_task_valid = 1'b0;
  endtask

  task automatic retire(input int row);
    retire_valid = 1'b1;
    retire_row   = IDX_W'(row);
    step();
    retire_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    disp_task_valid = 1'b0;
    disp_tile_done  = 1'b0;
    proc_ready      = 1'b0;
    retire_valid    = 1'b0;
    sb.delete();
    step();
    step();
    rst_n       = 1'b1;
    issue_count = 0;
    tc_count    = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    int   first, p, n;

    vecs[0] = '{0, 0,   3,   3,   1};
    vecs[1] = '{0, 0,   7,   3,   0};
    vecs[2] = '{1, 3,   7,   3,   1};
    vecs[3] = '{1, 4,   7,   3,   0};
    vecs[4] = '{1, 255, 0,   255, 1};
    vecs[5] = '{1, 0,   255, 0,   1};
    vecs[6] = '{0, 0,   255, 255, 1};
    vecs[7] = '{1, 200, 10,  201, 0};

    do_reset();
    check("rst_sched_ready", int'(sched_ready), 1);
    check("rst_proc_valid", int'(proc_valid), 0);
    check("rst_compute_busy", int'(compute_busy), 0);
    check("rst_tile_complete", int'(tile_complete), 0);
    check("rst_err_deadlock", int'(err_deadlock), 0);
    check("rst_err_overflow", int'(err_overflow), 0);

    // Head eligibility table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (vecs[i].do_ret) retire(vecs[i].ret_row);
      push_task(vecs[i].row, vecs[i].prefix, i + 1, 1'b0);
      check($sformatf("vec%0d_valid", i), int'(proc_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i), int'(compute_busy), 1);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_row", i), int'(proc_row_id), vecs[i].row);
    end

    // Independent tasks, then tile drain and completion
    do_reset();
    proc_ready = 1'b1;
    push_task(3, 3, 16'h00a3, 1'b1);
    push_task(5, 5, 16'h00b5, 1'b1);
    first = last_issue_cyc;
    step();
    check("indep_issue_count", issue_count, 2);
    check("indep_consecutive", last_issue_cyc - first, 1);
    check("indep_busy_inflight", int'(compute_busy), 1);
    retire(3);
    check("indep_busy_one_left", int'(compute_busy), 1);
    retire(5);
    check("indep_idle", int'(compute_busy), 0);
    tc_count = 0;
    disp_tile_done = 1'b1;
    step();
    disp_tile_done = 1'b0;
    check("drain_sched_ready", int'(sched_ready), 0);
    repeat (5) step();
    check("tile_complete_pulses", tc_count, 1);
    check("post_tile_ready", int'(sched_ready), 1);
    push_task(7, 3, 16'h0007, 1'b0);
    check("retired_cleared", int'(proc_valid), 0);

    // Prefix dependency: no same-cycle bypass
    do_reset();
    proc_ready = 1'b1;
    push_task(7, 3, 16'h1234, 1'b1);
    step();
    step();
    check("dep_blocked", int'(proc_valid), 0);
    retire_valid = 1'b1;
    retire_row   = IDX_W'(3);
    check("dep_no_bypass", int'(proc_valid), 0);
    step();
    retire_valid = 1'b0;
    check("dep_valid_next", int'(proc_valid), 1);
    check("dep_row", int'(proc_row_id), 7);
    step();
    check("dep_issued", issue_count, 1);

    // Backpressure with a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_task(10 + i, 10 + i, 16'h0100 + i, 1'b1);
      check($sformatf("bp_ready%0d", i), int'(sched_ready), (i < 2) ? 1 : 0);
      check($sformatf("bp_head%0d", i), int'(proc_row_id), 10);
    end
    proc_ready = 1'b1;
    repeat (6) step();
    check("bp_issue_count", issue_count, 4);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_no_overflow", int'(err_overflow), 0);

    // Push into a full FIFO is dropped
    do_reset();
    for (int i = 0; i < 4; i++) push_task(40 + i, 40 + i, 16'h0200 + i, 1'b1);
    check("ovf_clear", int'(err_overflow), 0);
    push_task(50, 50, 16'h0250, 1'b0);
    check("ovf_set", int'(err_overflow), 1);
    proc_ready = 1'b1;
    repeat (6) step();
    check("ovf_issue_count", issue_count, 4);
    check("ovf_sticky", int'(err_overflow), 1);

    // In-flight cap
    do_reset();
    proc_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_task(20 + i, 20 + i, 16'h0300 + i, 1'b1);
    repeat (3) step();
    check("cap_issue_count", issue_count, 8);
    check("cap_blocked", int'(proc_valid), 0);
    retire(20);
    check("cap_valid_after_retire", int'(proc_valid), 1);
    step();
    check("cap_ninth_issued", issue_count, 9);
    check("cap_sb_empty", sb.size(), 0);

    // Deadlock guard
    do_reset();
    proc_ready = 1'b1;
    push_task(9, 4, 16'h0909, 1'b1);
    p = cyc;
    for (int k = 0; k < 1000; k++) step();
    check("dl_not_early", issue_count, 0);
    check("dl_err_early", int'(err_deadlock), 0);
    n = 0;
    while (issue_count == 0 && n < 200) begin
      step();
      n++;
    end
    check("dl_issued", issue_count, 1);
    check("dl_issue_delay", last_issue_cyc - p, STALL_LIMIT - 1);
    check("dl_err_set", int'(err_deadlock), 1);
    repeat (3) step();
    check("dl_err_sticky", int'(err_deadlock), 1);
    do_reset();
    check("dl_err_reset", int'(err_deadlock), 0);

    // Reset while draining
    do_reset();
    push_task(60, 60, 16'h0600, 1'b0);
    push_task(61, 61, 16'h0601, 1'b0);
    disp_tile_done = 1'b1;
    step();
    disp_tile_done = 1'b0;
    check("rd_drain_ready", int'(sched_ready), 0);
    check("rd_busy", int'(compute_busy), 1);
    tc_count = 0;
    rst_n = 1'b0;
    #1;
    check("rd_proc_valid", int'(proc_valid), 0);
    check("rd_compute_busy", int'(compute_busy), 0);
    check("rd_sched_ready", int'(sched_ready), 1);
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("rd_no_tile_complete", tc_count, 0);
    check("rd_still_idle", int'(compute_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
